// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential 16/8 restoring divider.
package div_pkg;

  localparam int unsigned W_A_DEF = 16;
  localparam int unsigned W_B_DEF = 8;
  localparam int unsigned CNT_W   = $clog2(W_A_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem      current partial remainder (always < B)
//   bit_in   next dividend bit, MSB first
//   B        divisor
//   rem_next partial remainder after this step
//   q_bit    quotient bit produced by this step
module div_step #(
  parameter int unsigned W_B = 8
) (
  input  logic [W_B-1:0] rem,
  input  logic           bit_in,
  input  logic [W_B-1:0] B,
  output logic [W_B-1:0] rem_next,
  output logic           q_bit
);

  logic [W_B:0]   trial;
  logic [W_B-1:0] diff;

  // rem < B, so trial < 2*B and both candidate remainders fit W_B bits.
  always_comb begin
    trial    = {rem, bit_in};
    q_bit    = (trial >= {1'b0, B});
    diff     = W_B'(trial - {1'b0, B});
    rem_next = q_bit ? diff : trial[W_B-1:0];
  end

endmodule

// File: rtl/div16by8_seq.sv
// Sequential radix-2 restoring unsigned divider: A = Q*B + R, R < B.
// One division in flight; valid/ready on both sides.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (A dividend, B divisor)
//   out_valid/out_ready result handshake (Q quotient, R remainder, DBZ divide-by-zero)
module div16by8_seq
  import div_pkg::*;
#(
  parameter int unsigned W_A = W_A_DEF,
  parameter int unsigned W_B = W_B_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W_A-1:0] A,
  input  logic [W_B-1:0] B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W_A-1:0] Q,
  output logic [W_B-1:0] R,
  output logic           DBZ
);

  localparam int unsigned CW = $clog2(W_A);

  state_t         state, state_d;
  logic [W_A-1:0] dq, dq_d;        // dividend shifts out the MSB, quotient shifts in the LSB
  logic [W_B-1:0] rem, rem_d;
  logic [W_B-1:0] b_reg, b_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic           dbz, dbz_d;
  logic [W_A-1:0] q_d;
  logic [W_B-1:0] r_d;
  logic           dbz_out_d;
  logic           out_valid_d;
  logic           in_ready_d;
  logic [W_B-1:0] step_rem;
  logic           step_q;

  div_step #(.W_B(W_B)) u_step (
    .rem      (rem),
    .bit_in   (dq[W_A-1]),
    .B        (b_reg),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dq        <= '0;
      rem       <= '0;
      b_reg     <= '0;
      cnt       <= '0;
      dbz       <= 1'b0;
      Q         <= '0;
      R         <= '0;
      DBZ       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_d;
      dq        <= dq_d;
      rem       <= rem_d;
      b_reg     <= b_d;
      cnt       <= cnt_d;
      dbz       <= dbz_d;
      Q         <= q_d;
      R         <= r_d;
      DBZ       <= dbz_out_d;
      out_valid <= out_valid_d;
      in_ready  <= in_ready_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state;
    dq_d        = dq;
    rem_d       = rem;
    b_d         = b_reg;
    cnt_d       = cnt;
    dbz_d       = dbz;
    q_d         = Q;
    r_d         = R;
    dbz_out_d   = DBZ;
    out_valid_d = out_valid;

    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          b_d = B;
          if (B != '0) begin
            dq_d    = A;
            rem_d   = '0;
            cnt_d   = CW'(W_A - 1);
            dbz_d   = 1'b0;
            state_d = BUSY;
          end else begin
            dq_d    = '1;
            rem_d   = A[W_B-1:0];
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        dq_d  = {dq[W_A-2:0], step_q};
        rem_d = step_rem;
        cnt_d = cnt - CW'(1);
        if (cnt == '0) state_d = DONE;
      end
      DONE: begin
        // First DONE cycle commits the result to the output registers.
        if (!out_valid) begin
          q_d         = dq;
          r_d         = rem;
          dbz_out_d   = dbz;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

endmodule

// File: tb/tb_div16by8_seq.sv
// Self-checking bench for div16by8_seq: directed cases plus randomized handshake traffic
// checked against plain integer division and a split-byte multiply identity.
module tb_div16by8_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [7:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Q;
  logic [7:0]  R;
  logic        DBZ;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div16by8_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .R         (R),
    .DBZ       (DBZ)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference result from the arithmetic definition.
  task automatic ref_div(input logic [15:0] a, input logic [7:0] b,
                         output logic [15:0] eq, output logic [7:0] er, output logic ed);
    if (b == 8'd0) begin
      eq = 16'hFFFF; er = a[7:0]; ed = 1'b1;
    end else begin
      eq = a / 16'(b); er = 8'(a % 16'(b)); ed = 1'b0;
    end
  endtask

  // One directed division, with 'hold' cycles of backpressure before accepting the result.
  task automatic run_one(input logic [15:0] a, input logic [7:0] b, input int hold);
    int          lat;
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ed;
    ref_div(a, b, eq, er, ed);
    lat = 0;
    while (!in_ready && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk("ready_wait", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = 16'($urandom); B = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
      if (!out_valid) chk("busy_in_ready", 32'(in_ready), 32'd0);
    end
    chk("latency", 32'(lat), (b == 8'd0) ? 32'd1 : 32'd17);
    chk("q", 32'(Q), 32'(eq));
    chk("r", 32'(R), 32'(er));
    chk("dbz", 32'(DBZ), 32'(ed));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_q", 32'(Q), 32'(eq));
      chk("hold_r", 32'(R), 32'(er));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drop_valid", 32'(out_valid), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  localparam int N_RAND = 1500;

  initial begin
    logic [15:0] qa[$];
    logic [7:0]  qb[$];
    logic [15:0] ea, eq;
    logic [7:0]  eb, er;
    logic        ed;
    logic [31:0] recon;
    int          sent, recv, cyc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q", 32'(Q), 32'd0);
    chk("rst_r", 32'(R), 32'd0);
    chk("rst_dbz", 32'(DBZ), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_one(16'd45000, 8'd200, 0);
    run_one(16'd65535, 8'd255, 0);
    run_one(16'd1000, 8'd7, 0);
    run_one(16'd1000, 8'd0, 0);
    run_one(16'd65535, 8'd1, 10);

    // Reset in the middle of an iteration sequence aborts the division.
    A = 16'd40000; B = 8'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_q", 32'(Q), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_result", 32'(out_valid), 32'd0);
    run_one(16'd300, 8'd3, 0);

    // Random traffic with random in_valid/out_ready.
    sent = 0; recv = 0; cyc = 0;
    while (recv < N_RAND && cyc < 60000) begin
      in_valid  = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       A = 16'hFFFF;
        1:       A = 16'h0000;
        default: A = 16'($urandom);
      endcase
      B         = 8'($urandom_range(1, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) begin
        qa.push_back(A); qb.push_back(B); sent++;
      end
      if (out_valid && out_ready) begin
        if (qa.size() == 0) begin
          chk("spurious_result", 32'd1, 32'd0);
        end else begin
          ea = qa.pop_front(); eb = qb.pop_front();
          ref_div(ea, eb, eq, er, ed);
          recon = ((32'(Q[15:8]) * 32'(eb)) << 8) + 32'(Q[7:0]) * 32'(eb) + 32'(R);
          chk("rand_identity", recon, 32'(ea));
          chk("rand_r_lt_b", 32'(R < eb), 32'd1);
          chk("rand_q", 32'(Q), 32'(eq));
          chk("rand_dbz", 32'(DBZ), 32'(ed));
        end
        recv++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rand_count", 32'(recv), 32'(N_RAND));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
